// File: rtl/write_back_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : write_back_unit_pkg
//  Description : Shared types for the write-back stage: result-source select,
//                load size/sign encodings and the WB pipeline control record.
//  Revision    : 1.0 - initial release
// ============================================================================
package write_back_unit_pkg;

   localparam int c_FUNCT3_W = 3;

   // Result source chosen for the register-file write
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_NONE = 2'd3
   } wb_sel_e;

   // Load size/sign encodings carried on funct3
   typedef enum logic [c_FUNCT3_W-1:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

   // Control half of the MEM/WB register; the datapath fields live beside it
   // because their widths follow the module parameters.
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      wb_sel_e               wb_sel;
      logic [c_FUNCT3_W-1:0] funct3;
   } wb_pipe_t;

endpackage : write_back_unit_pkg
`default_nettype wire

// File: rtl/write_back_unit_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : write_back_unit_load_extend
//  Description : Combinational load extraction. Picks the byte/half/word out of
//                the aligned memory word and sign- or zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_back_unit_load_extend
   import write_back_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [c_FUNCT3_W-1:0] funct3,
   input  logic [1:0]            byte_off,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select: half-word uses only off[1]; misalignment never reaches here
   always_comb begin
      w_byte = word[{byte_off, 3'b000} +: 8];
      w_half = word[{byte_off[1], 4'b0000} +: 16];
   end

   // Extension by funct3; unknown encodings pass the whole word through
   always_comb begin
      load_data = word;
      case (funct3)
         LB:      load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         LH:      load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         LBU:     load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         LHU:     load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
         LW:      load_data = word;
         default: load_data = word;
      endcase
   end

endmodule : write_back_unit_load_extend
`default_nettype wire

// File: rtl/write_back_unit.sv
`default_nettype none
// ============================================================================
//  Module      : write_back_unit
//  Description : Registered write-back stage. Holds the MEM/WB entry, forms
//                its result, and arbitrates the single RF write port between
//                the in-order pipe and NUM_EXT long-latency result channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_back_unit
   import write_back_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_EXT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_MEM,
   input  logic                           reg_write_MEM,
   input  wb_sel_e                        WBSel_MEM,
   input  logic [c_FUNCT3_W-1:0]          funct3_MEM,
   input  logic [DATA_WIDTH-1:0]          alu_result_MEM,
   input  logic [DATA_WIDTH-1:0]          rd_data_MEM,
   input  logic [DATA_WIDTH-1:0]          pc_plus4_MEM,
   input  logic [REG_ADDR_W-1:0]          rd_addr_MEM,
   input  logic [NUM_EXT-1:0]             ext_valid,
   input  logic [NUM_EXT*REG_ADDR_W-1:0]  ext_rd_addr,
   input  logic [NUM_EXT*DATA_WIDTH-1:0]  ext_data,
   output logic [NUM_EXT-1:0]             ext_ready,
   output logic                           stall_req_WB,
   output logic                           rf_we,
   output logic [REG_ADDR_W-1:0]          rf_waddr,
   output logic [DATA_WIDTH-1:0]          rf_wdata
);

   localparam int c_PTR_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
   localparam int c_CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(STARVE_MAX);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_EXT - 1);

   // MEM/WB register
   wb_pipe_t              r_wb_ctrl;
   logic [DATA_WIDTH-1:0] r_wb_alu;
   logic [DATA_WIDTH-1:0] r_wb_word;
   logic [DATA_WIDTH-1:0] r_wb_pc4;
   logic [REG_ADDR_W-1:0] r_wb_rd;

   // Arbitration state
   logic [c_PTR_W-1:0]    r_rr_ptr;
   logic [c_CNT_W-1:0]    r_starve_cnt;

   logic                  w_active;
   logic                  w_pipe_wr;
   logic                  w_ext_req;
   logic                  w_ext_win;
   logic                  w_stall;
   logic                  w_found;
   logic [c_PTR_W-1:0]    w_grant_idx;
   logic [c_PTR_W-1:0]    w_rr_next;
   logic [c_CNT_W-1:0]    w_cnt_next;
   logic [REG_ADDR_W-1:0] w_ext_addr;
   logic [DATA_WIDTH-1:0] w_ext_wdata;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic [DATA_WIDTH-1:0] w_wb_data;

   // Channel index k steps after base, wrapped into [0, NUM_EXT)
   function automatic logic [c_PTR_W-1:0] rr_index(input logic [c_PTR_W-1:0] base,
                                                   input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_EXT) s = s - NUM_EXT;
      return c_PTR_W'(s);
   endfunction

   write_back_unit_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .funct3    (r_wb_ctrl.funct3),
      .byte_off  (r_wb_alu[1:0]),
      .word      (r_wb_word),
      .load_data (w_load_data)
   );

   // Request qualification; reset masks all outputs so nothing is accepted
   // or written while the stage is being cleared.
   always_comb begin
      w_active  = !rst;
      w_pipe_wr = w_active && r_wb_ctrl.valid && r_wb_ctrl.reg_write &&
                  (r_wb_ctrl.wb_sel != WB_NONE) && (r_wb_rd != '0);
      w_ext_req = w_active && (|ext_valid);
      w_ext_win = w_ext_req && (!w_pipe_wr || (r_starve_cnt == c_CNT_MAX));
      w_stall   = w_ext_win && w_pipe_wr;
   end

   // Round-robin search: first valid channel at or after r_rr_ptr
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < NUM_EXT; k++) begin
         if (!w_found && ext_valid[rr_index(r_rr_ptr, k)]) begin
            w_found     = 1'b1;
            w_grant_idx = rr_index(r_rr_ptr, k);
         end
      end
      w_rr_next   = (w_grant_idx == c_PTR_LAST) ? '0 : w_grant_idx + c_PTR_W'(1);
      w_ext_addr  = ext_rd_addr[w_grant_idx*REG_ADDR_W +: REG_ADDR_W];
      w_ext_wdata = ext_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   // Starvation counter: cleared by a grant or an idle ext side, saturating
   always_comb begin
      w_cnt_next = r_starve_cnt;
      if (!w_ext_req || w_ext_win) begin
         w_cnt_next = '0;
      end else if (r_starve_cnt != c_CNT_MAX) begin
         w_cnt_next = r_starve_cnt + c_CNT_W'(1);
      end
   end

   // Pipe result source select
   always_comb begin
      w_wb_data = '0;
      case (r_wb_ctrl.wb_sel)
         WB_ALU:  w_wb_data = r_wb_alu;
         WB_MEM:  w_wb_data = w_load_data;
         WB_PC4:  w_wb_data = r_wb_pc4;
         default: w_wb_data = '0;
      endcase
   end

   // RF port drive and one-hot grant; ext writes to x0 are dropped too
   always_comb begin
      ext_ready    = '0;
      rf_we        = 1'b0;
      rf_waddr     = '0;
      rf_wdata     = '0;
      stall_req_WB = w_stall;
      if (w_ext_win) begin
         ext_ready[w_grant_idx] = 1'b1;
         rf_we                  = (w_ext_addr != '0);
         rf_waddr               = w_ext_addr;
         rf_wdata               = w_ext_wdata;
      end else if (w_pipe_wr) begin
         rf_we    = 1'b1;
         rf_waddr = r_wb_rd;
         rf_wdata = w_wb_data;
      end
   end

   // MEM/WB register: loads every cycle unless the stage is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_ctrl <= '0;
         r_wb_alu  <= '0;
         r_wb_word <= '0;
         r_wb_pc4  <= '0;
         r_wb_rd   <= '0;
      end else if (!w_stall) begin
         r_wb_ctrl <= '{valid:     valid_MEM,
                        reg_write: reg_write_MEM,
                        wb_sel:    WBSel_MEM,
                        funct3:    funct3_MEM};
         r_wb_alu  <= alu_result_MEM;
         r_wb_word <= rd_data_MEM;
         r_wb_pc4  <= pc_plus4_MEM;
         r_wb_rd   <= rd_addr_MEM;
      end
   end

   // Arbitration state update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr     <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (w_ext_win && w_found) r_rr_ptr <= w_rr_next;
         r_starve_cnt <= w_cnt_next;
      end
   end

endmodule : write_back_unit
`default_nettype wire

// File: tb/tb_write_back_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_back_unit
//  Description : Directed self-checking bench for write_back_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back_unit;
   import write_back_unit_pkg::*;

   logic          clk;
   logic          rst;
   logic          valid_MEM;
   logic          reg_write_MEM;
   wb_sel_e       WBSel_MEM;
   logic [2:0]    funct3_MEM;
   logic [31:0]   alu_result_MEM;
   logic [31:0]   rd_data_MEM;
   logic [31:0]   pc_plus4_MEM;
   logic [4:0]    rd_addr_MEM;
   logic [1:0]    ext_valid;
   logic [9:0]    ext_rd_addr;
   logic [63:0]   ext_data;
   logic [1:0]    ext_ready;
   logic          stall_req_WB;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;

   int n_total = 0;
   int n_bad   = 0;

   write_back_unit #(
      .DATA_WIDTH (32),
      .REG_ADDR_W (5),
      .NUM_EXT    (2),
      .STARVE_MAX (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_MEM      (valid_MEM),
      .reg_write_MEM  (reg_write_MEM),
      .WBSel_MEM      (WBSel_MEM),
      .funct3_MEM     (funct3_MEM),
      .alu_result_MEM (alu_result_MEM),
      .rd_data_MEM    (rd_data_MEM),
      .pc_plus4_MEM   (pc_plus4_MEM),
      .rd_addr_MEM    (rd_addr_MEM),
      .ext_valid      (ext_valid),
      .ext_rd_addr    (ext_rd_addr),
      .ext_data       (ext_data),
      .ext_ready      (ext_ready),
      .stall_req_WB   (stall_req_WB),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic v, input logic rw, input wb_sel_e sel,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] word, input logic [31:0] pc4,
                          input logic [4:0] rd);
      valid_MEM      = v;
      reg_write_MEM  = rw;
      WBSel_MEM      = sel;
      funct3_MEM     = f3;
      alu_result_MEM = alu;
      rd_data_MEM    = word;
      pc_plus4_MEM   = pc4;
      rd_addr_MEM    = rd;
   endtask

   task automatic check_load(input string tag, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] exp);
      set_mem(1'b1, 1'b1, WB_MEM, f3, alu, 32'h8000_7F80, 32'h0, 5'd3);
      tick();
      check_val({tag, "_we"}, {31'd0, rf_we}, 32'd1);
      check_val({tag, "_addr"}, {27'd0, rf_waddr}, 32'd3);
      check_val({tag, "_data"}, rf_wdata, exp);
   endtask

   initial begin
      rst = 1'b1;
      set_mem(1'b0, 1'b0, WB_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
      ext_valid   = 2'b00;
      ext_rd_addr = {5'd8, 5'd7};
      ext_data    = {32'h1111_0008, 32'hAAAA_0007};

      // Reset cycle and the cycle after
      tick();
      check_val("rst_we", {31'd0, rf_we}, 32'd0);
      check_val("rst_ready", {30'd0, ext_ready}, 32'd0);
      check_val("rst_stall", {31'd0, stall_req_WB}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("post_rst_we", {31'd0, rf_we}, 32'd0);
      check_val("post_rst_stall", {31'd0, stall_req_WB}, 32'd0);

      // Load extraction on word 0x8000_7F80
      check_load("lb0",   3'b000, 32'h0000_1000, 32'hFFFF_FF80);
      check_load("lbu3",  3'b100, 32'h0000_1003, 32'h0000_0080);
      check_load("lh2",   3'b001, 32'h0000_1002, 32'hFFFF_8000);
      check_load("lhu0",  3'b101, 32'h0000_1000, 32'h0000_7F80);
      check_load("lw",    3'b010, 32'h0000_1000, 32'h8000_7F80);
      check_load("lb1",   3'b000, 32'h0000_1001, 32'h0000_007F);
      check_load("undef", 3'b011, 32'h0000_1002, 32'h8000_7F80);

      // Starvation: pipe writes x5 every cycle, ext0 loses four times
      set_mem(1'b1, 1'b1, WB_ALU, 3'b000, 32'h55, 32'h0, 32'h0, 5'd5);
      tick();
      ext_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("starve%0d_ready", i), {30'd0, ext_ready}, 32'd0);
         check_val($sformatf("starve%0d_addr", i), {27'd0, rf_waddr}, 32'd5);
         check_val($sformatf("starve%0d_stall", i), {31'd0, stall_req_WB}, 32'd0);
         tick();
      end
      check_val("force_ready", {30'd0, ext_ready}, 32'd1);
      check_val("force_addr", {27'd0, rf_waddr}, 32'd7);
      check_val("force_data", rf_wdata, 32'hAAAA_0007);
      check_val("force_stall", {31'd0, stall_req_WB}, 32'd1);
      // Upstream would hold; a changed MEM input proves the WB register held
      set_mem(1'b1, 1'b1, WB_ALU, 3'b000, 32'h99, 32'h0, 32'h0, 5'd9);
      tick();
      ext_valid = 2'b00;
      #1;
      check_val("held_we", {31'd0, rf_we}, 32'd1);
      check_val("held_addr", {27'd0, rf_waddr}, 32'd5);
      check_val("held_data", rf_wdata, 32'h55);
      check_val("held_stall", {31'd0, stall_req_WB}, 32'd0);
      check_val("held_cnt", {29'd0, dut.r_starve_cnt}, 32'd0);
      tick();
      check_val("after_hold_addr", {27'd0, rf_waddr}, 32'd9);
      check_val("after_hold_data", rf_wdata, 32'h99);

      // Round-robin with WB bubble, starting from a fresh pointer
      rst = 1'b1;
      set_mem(1'b0, 1'b0, WB_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      rst = 1'b0;
      ext_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("rr%0d_ready", i), {30'd0, ext_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         check_val($sformatf("rr%0d_addr", i), {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd7 : 32'd8);
         check_val($sformatf("rr%0d_stall", i), {31'd0, stall_req_WB}, 32'd0);
         tick();
      end
      ext_valid = 2'b00;

      // x0 destination never counts as a pipe write
      set_mem(1'b1, 1'b1, WB_ALU, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd0);
      tick();
      ext_valid = 2'b10;
      #1;
      check_val("x0_ready", {30'd0, ext_ready}, 32'd2);
      check_val("x0_stall", {31'd0, stall_req_WB}, 32'd0);
      check_val("x0_addr", {27'd0, rf_waddr}, 32'd8);
      tick();
      ext_valid = 2'b00;
      #1;
      check_val("x0_we", {31'd0, rf_we}, 32'd0);

      // WB_NONE writes nothing; WB_PC4 writes pc+4
      set_mem(1'b1, 1'b1, WB_NONE, 3'b000, 32'h0, 32'h0, 32'h104, 5'd1);
      tick();
      check_val("none_we", {31'd0, rf_we}, 32'd0);
      set_mem(1'b1, 1'b1, WB_PC4, 3'b000, 32'h0, 32'h0, 32'h104, 5'd1);
      tick();
      check_val("pc4_we", {31'd0, rf_we}, 32'd1);
      check_val("pc4_addr", {27'd0, rf_waddr}, 32'd1);
      check_val("pc4_data", rf_wdata, 32'h104);

      // Move the pointer off zero with one ext0 grant on a bubble
      set_mem(1'b0, 1'b0, WB_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      ext_valid = 2'b01;
      #1;
      check_val("pre_ready", {30'd0, ext_ready}, 32'd1);
      tick();
      ext_valid = 2'b00;
      check_val("pre_ptr", {31'd0, dut.r_rr_ptr}, 32'd1);

      // Reset arriving in a stall cycle
      set_mem(1'b1, 1'b1, WB_ALU, 3'b000, 32'h55, 32'h0, 32'h0, 5'd5);
      tick();
      ext_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("rs%0d_ready", i), {30'd0, ext_ready}, 32'd0);
         tick();
      end
      check_val("rs_stall", {31'd0, stall_req_WB}, 32'd1);
      rst = 1'b1;
      set_mem(1'b0, 1'b0, WB_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      check_val("rs_we", {31'd0, rf_we}, 32'd0);
      check_val("rs_ready", {30'd0, ext_ready}, 32'd0);
      check_val("rs_stall_clr", {31'd0, stall_req_WB}, 32'd0);
      check_val("rs_ptr", {31'd0, dut.r_rr_ptr}, 32'd0);
      check_val("rs_cnt", {29'd0, dut.r_starve_cnt}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("rs_pending_ready", {30'd0, ext_ready}, 32'd1);
      check_val("rs_pending_addr", {27'd0, rf_waddr}, 32'd7);
      check_val("rs_pending_we", {31'd0, rf_we}, 32'd1);
      tick();
      ext_valid = 2'b00;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_write_back_unit
`default_nettype wire
